// File: rtl/debug_run_controller.sv
// -----------------------------------------------------------------------------
// debug_run_controller
//   Run/step sequencer for the pipelined MIPS core on the UART debug path.
//   Single-byte commands from the UART receiver start a continuous run, a
//   single step, a soft reset (pipeline flush plus counter clear) or a dump.
//   A dump streams the executed-cycle count to the UART transmitter, least
//   significant byte first. The pipeline stops on HALT or on a watchdog expiry.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   cmd_data      in   received command byte
//   cmd_valid     in   one-cycle strobe qualifying cmd_data
//   halt_detected in   decode stage holds the HALT opcode
//   tx_ready      in   transmitter can accept a byte
//   pipe_en       out  clock enable for pipeline registers and PC
//   pipe_flush    out  one-cycle synchronous clear for pipeline registers
//   tx_data       out  byte to transmit
//   tx_valid      out  tx_data valid
//   cycle_count   out  enabled pipeline cycles since the last clear
//   halted        out  pipeline stopped by HALT or watchdog
//   timeout       out  stop was caused by the watchdog
//   busy          out  dump in progress, commands ignored
// -----------------------------------------------------------------------------
module debug_run_controller #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WATCHDOG = 1000000,
  parameter logic [7:0]  CMD_RUN  = 8'h63,
  parameter logic [7:0]  CMD_STEP = 8'h73,
  parameter logic [7:0]  CMD_RST  = 8'h72,
  parameter logic [7:0]  CMD_DUMP = 8'h64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_valid,
  input  logic             halt_detected,
  input  logic             tx_ready,
  output logic             pipe_en,
  output logic             pipe_flush,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned     NBYTES   = CNT_W / 8;
  localparam int unsigned     BW       = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG);
  localparam logic [BW-1:0]   BYTES_ALL = BW'(NBYTES);
  localparam logic [BW-1:0]   BYTE_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED,
    S_DUMP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             flush_q, flush_d;
  logic             ret_halted_q, ret_halted_d;   // dump returns to HALTED
  logic [CNT_W-1:0] shift_q, shift_d;             // snapshot, shifted per byte
  logic [BW-1:0]    left_q, left_d;               // bytes still to send
  logic             txv_q, txv_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             is_run, is_step, is_rst, is_dump;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign is_run  = cmd_valid && (cmd_data == CMD_RUN);
  assign is_step = cmd_valid && (cmd_data == CMD_STEP);
  assign is_rst  = cmd_valid && (cmd_data == CMD_RST);
  assign is_dump = cmd_valid && (cmd_data == CMD_DUMP);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    flush_d      = 1'b0;
    ret_halted_d = ret_halted_q;
    shift_d      = shift_q;
    left_d       = left_q;
    txv_d        = txv_q;

    case (state_q)
      S_IDLE: begin
        if (is_run) begin
          state_d = S_RUN;
        end else if (is_step) begin
          state_d = S_STEP;
        end else if (is_dump) begin
          state_d      = S_DUMP;
          ret_halted_d = 1'b0;
          shift_d      = cnt_q;
          left_d       = BYTES_ALL;
          txv_d        = 1'b1;
        end else if (is_rst) begin
          flush_d   = 1'b1;
          cnt_d     = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt_detected) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if ((WATCHDOG != 0) && (cnt_inc == WD_LIMIT)) begin
          state_d   = S_HALTED;
          halted_d  = 1'b1;
          timeout_d = 1'b1;
        end
      end

      S_STEP: begin
        cnt_d = cnt_inc;
        if (halt_detected) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HALTED: begin
        if (is_dump) begin
          state_d      = S_DUMP;
          ret_halted_d = 1'b1;
          shift_d      = cnt_q;
          left_d       = BYTES_ALL;
          txv_d        = 1'b1;
        end else if (is_rst) begin
          state_d   = S_IDLE;
          flush_d   = 1'b1;
          cnt_d     = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end

      S_DUMP: begin
        if (txv_q && tx_ready) begin
          if (left_q == BYTE_ONE) begin
            txv_d   = 1'b0;
            shift_d = '0;
            left_d  = '0;
            state_d = ret_halted_q ? S_HALTED : S_IDLE;
          end else begin
            shift_d = shift_q >> 8;
            left_d  = left_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      flush_q      <= 1'b0;
      ret_halted_q <= 1'b0;
      shift_q      <= '0;
      left_q       <= '0;
      txv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      flush_q      <= flush_d;
      ret_halted_q <= ret_halted_d;
      shift_q      <= shift_d;
      left_q       <= left_d;
      txv_q        <= txv_d;
    end
  end

  assign pipe_en     = (state_q == S_RUN) || (state_q == S_STEP);
  assign busy        = (state_q == S_DUMP);
  assign pipe_flush  = flush_q;
  assign tx_data     = shift_q[7:0];
  assign tx_valid    = txv_q;
  assign cycle_count = cnt_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Sequences the pipelined MIPS core for the debug path.
- Decodes single-byte commands from the UART receiver into run, step, soft-reset and dump actions.
- Drives one global pipeline enable, stops the pipeline on a HALT instruction or a watchdog expiry, and streams the executed-cycle count back through the UART transmitter using a valid/ready handshake.

Parameters:
- CNT_W, 32: cycle counter width. Must be a multiple of 8.
- WATCHDOG, 1000000: forced halt after this many RUN cycles. 0 disables the watchdog.
- CMD_RUN, 8'h63: 'c', continuous run.
- CMD_STEP, 8'h73: 's', single cycle.
- CMD_RST, 8'h72: 'r', pipeline flush and counter clear.
- CMD_DUMP, 8'h64: 'd', transmit the cycle count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_data  in  8  received command byte.
- cmd_valid  in  1  one-cycle strobe qualifying cmd_data.
- halt_detected  in  1  decode stage currently holds the HALT opcode.
- tx_ready  in  1  transmitter can accept a byte.
- pipe_en  out  1  clock enable for all pipeline registers and the PC.
- pipe_flush  out  1  one-cycle synchronous clear for the pipeline registers.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- cycle_count  out  CNT_W  number of enabled pipeline cycles since the last clear.
- halted  out  1  pipeline stopped by HALT or watchdog.
- timeout  out  1  stop was caused by the watchdog.
- busy  out  1  a DUMP is in progress; commands are ignored.

Behaviour:
- Reset state: IDLE. Every output is 0 (pipe_en, pipe_flush, tx_data, tx_valid, cycle_count, halted, timeout, busy). Any partially completed dump is abandoned.
- Reset mid-operation: rst_n asserted at any time forces the reset state immediately and asynchronously, including dropping tx_valid in the middle of a dump.
- Output timing: pipe_en and busy are Moore outputs. pipe_en = (state==RUN || state==STEP). busy = (state==DUMP).
- Command timing: a command accepted at edge N changes the state at edge N, so its effect is visible in cycle N+1.
- Unrecognised command bytes: ignored in every state.
- IDLE:
  - CMD_RUN -> RUN.
  - CMD_STEP -> STEP.
  - CMD_DUMP -> DUMP, returning to IDLE.
  - CMD_RST -> stay in IDLE, with the soft-reset actions below.
- RUN:
  - Each cycle, cycle_count increments by 1, saturating at all-ones.
  - Commands are ignored.
  - If halt_detected=1 at an edge -> HALTED with halted=1. The HALT cycle is counted.
  - Else, if WATCHDOG!=0 and the incremented count equals WATCHDOG -> HALTED with halted=1 and timeout=1.
  - HALT takes priority over the watchdog on the same edge; timeout stays 0.
- STEP:
  - Exactly one enabled cycle; count increments by 1.
  - Next state is HALTED if halt_detected=1, otherwise IDLE.
  - The watchdog is not evaluated in STEP.
- HALTED:
  - pipe_en=0.
  - CMD_DUMP -> DUMP, returning to HALTED.
  - CMD_RST -> IDLE with the soft-reset actions below.
  - CMD_RUN and CMD_STEP are ignored.
- Soft reset (CMD_RST in IDLE or HALTED):
  - pipe_flush=1 for exactly cycle N+1.
  - cycle_count, halted and timeout all reach 0 in that same cycle.
- DUMP:
  - On entry, snapshot cycle_count.
  - Send CNT_W/8 bytes, least-significant byte first.
  - tx_valid rises the cycle after entry.
  - tx_data holds stable while tx_valid=1 && tx_ready=0.
  - A byte is consumed at an edge where tx_valid && tx_ready. The next byte presents on the following cycle, with no idle gap required.
  - After the last byte is consumed, tx_valid=0 and the state returns to the saved state.
  - cmd_valid during DUMP is dropped; no queueing.
- Counter saturation: at all-ones the counter holds. RUN continues until HALT or the watchdog fires.

Test Plan:
- Reset release, then CMD_STEP three times with gaps -> pipe_en high for exactly 3 single cycles, each the cycle after its command; cycle_count=3; state IDLE; halted=0.
- CMD_RUN, with halt_detected pulsed after 10 enabled cycles -> pipe_en low from the next cycle; cycle_count=10; halted=1; timeout=0. A following CMD_STEP is ignored (count stays 10).
- WATCHDOG=20, CMD_RUN, halt_detected never asserted -> stop after cycle_count=20 with halted=1 and timeout=1. CMD_RST -> pipe_flush=1 for one cycle; count, halted and timeout all 0; state IDLE.
- cycle_count=0x12345678, CMD_DUMP with tx_ready toggling 1,0,0,1,... -> bytes 78,56,34,12 transmitted in order, each held stable while stalled. busy=1 throughout; a CMD_RUN sent mid-dump is ignored; state returns to HALTED/IDLE.
- CMD_STEP in the same cycle halt_detected=1 is seen -> count=1 and state HALTED.
- rst_n pulsed low during RUN and during DUMP (after byte 2) -> all outputs 0 immediately; no further tx bytes; state IDLE.
